// File: rtl/pre_encoding_pipe_if.sv
// Handshake and data bundle for the LZA pre-encoder pipe.
// The master drives the operands and consumes the strings. The slave is the pipe itself.
interface pre_encoding_pipe_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_A;
  logic [DATA_WIDTH-1:0] data_B;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] string_n_pos;
  logic [DATA_WIDTH-1:0] string_z_pos;
  logic [DATA_WIDTH-1:0] string_p_pos;
  logic [DATA_WIDTH-1:0] string_n_neg;
  logic [DATA_WIDTH-1:0] string_z_neg;
  logic [DATA_WIDTH-1:0] string_p_neg;
  logic [DATA_WIDTH-1:0] f_pos;
  logic [DATA_WIDTH-1:0] f_neg;
  logic [CNT_W-1:0]      lzc_pos;
  logic [CNT_W-1:0]      lzc_neg;

  modport master (
    output in_valid, data_A, data_B, sub, out_ready,
    input  in_ready, out_valid,
    input  string_n_pos, string_z_pos, string_p_pos,
    input  string_n_neg, string_z_neg, string_p_neg,
    input  f_pos, f_neg, lzc_pos, lzc_neg
  );

  modport slave (
    input  in_valid, data_A, data_B, sub, out_ready,
    output in_ready, out_valid,
    output string_n_pos, string_z_pos, string_p_pos,
    output string_n_neg, string_z_neg, string_p_neg,
    output f_pos, f_neg, lzc_pos, lzc_neg
  );
endinterface

// File: rtl/pre_encoding_pipe.sv
// Two-stage LZA pre-encoder. Stage 1 registers the e/g/s digit classes of A and B'.
// Stage 2 registers the positive- and negative-result n/z/p strings, the nonzero-digit
// indicators and, when LZA_LZC_EN is defined, the leading-zero counts of the indicators.
// Without LZA_LZC_EN the count ports are tied to zero and no encoder is built.
// Valid/ready elastic pipe: a stage advances when it is empty or its successor advances.
module pre_encoding_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pre_encoding_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  // Leading zeros from the MSB; an all-zero vector counts as DATA_WIDTH.
  function automatic logic [CNT_W-1:0] lead_zeros(input logic [DATA_WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    logic             hit;
    cnt = '0;
    hit = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      cnt = cnt + CNT_W'(1);
      end
    end
    return cnt;
  endfunction

  logic                  en1, en2;
  logic [DATA_WIDTH-1:0] b_eff;

  // e[0] is never consumed (only e[i+1] feeds the strings), so stage 1 keeps e[MSB:1].
  logic                  vld_p1_q, vld_p1_d;
  logic [DATA_WIDTH-1:1] e_p1_q, e_p1_d;
  logic [DATA_WIDTH-1:0] g_p1_q, g_p1_d;
  logic [DATA_WIDTH-1:0] s_p1_q, s_p1_d;

  logic [DATA_WIDTH-1:0] n_pos_c, p_pos_c, z_pos_c;
  logic [DATA_WIDTH-1:0] n_neg_c, p_neg_c, z_neg_c;

  logic                  vld_p2_q, vld_p2_d;
  logic [DATA_WIDTH-1:0] n_pos_p2_q, n_pos_p2_d;
  logic [DATA_WIDTH-1:0] z_pos_p2_q, z_pos_p2_d;
  logic [DATA_WIDTH-1:0] p_pos_p2_q, p_pos_p2_d;
  logic [DATA_WIDTH-1:0] n_neg_p2_q, n_neg_p2_d;
  logic [DATA_WIDTH-1:0] z_neg_p2_q, z_neg_p2_d;
  logic [DATA_WIDTH-1:0] p_neg_p2_q, p_neg_p2_d;
  logic [DATA_WIDTH-1:0] f_pos_p2_q, f_pos_p2_d;
  logic [DATA_WIDTH-1:0] f_neg_p2_q, f_neg_p2_d;

  assign en2          = ~vld_p2_q | bus.out_ready;
  assign en1          = ~vld_p1_q | en2;
  assign bus.in_ready = en1;
  assign b_eff        = bus.sub ? ~bus.data_B : bus.data_B;

  // ---- stage 1: operand digit classes ----
  // Next state of stage 1: capture e/g/s of the accepted operands.
  always_comb begin
    vld_p1_d = vld_p1_q;
    e_p1_d   = e_p1_q;
    g_p1_d   = g_p1_q;
    s_p1_d   = s_p1_q;
    if (en1) begin
      vld_p1_d = bus.in_valid;
      if (bus.in_valid) begin
        e_p1_d = ~(bus.data_A[DATA_WIDTH-1:1] ^ b_eff[DATA_WIDTH-1:1]);
        g_p1_d = bus.data_A & b_eff;
        s_p1_d = ~bus.data_A & ~b_eff;
      end
    end
  end

  // Stage 1 registers, cleared immediately by reset so in-flight work is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      e_p1_q   <= '0;
      g_p1_q   <= '0;
      s_p1_q   <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      e_p1_q   <= e_p1_d;
      g_p1_q   <= g_p1_d;
      s_p1_q   <= s_p1_d;
    end
  end

  // ---- stage 2: digit strings, indicators and counts ----
  // Positive- and negative-result n/z/p strings from the stage-1 classes.
  always_comb begin
    p_pos_c = '0;
    n_pos_c = '0;
    p_neg_c = '0;
    n_neg_c = '0;
    p_pos_c[0]            = g_p1_q[0] | s_p1_q[0];
    n_neg_c[0]            = s_p1_q[0] | g_p1_q[0];
    n_pos_c[DATA_WIDTH-1] = s_p1_q[DATA_WIDTH-1];
    p_neg_c[DATA_WIDTH-1] = g_p1_q[DATA_WIDTH-1];
    for (int i = 1; i < DATA_WIDTH; i++) begin
      p_pos_c[i] = (g_p1_q[i] | s_p1_q[i]) & ~s_p1_q[i-1];
      n_neg_c[i] = (s_p1_q[i] | g_p1_q[i]) & ~g_p1_q[i-1];
    end
    for (int i = 0; i < DATA_WIDTH - 1; i++) begin
      n_pos_c[i] = e_p1_q[i+1] & s_p1_q[i];
      p_neg_c[i] = e_p1_q[i+1] & g_p1_q[i];
    end
    z_pos_c = ~p_pos_c & ~n_pos_c;
    z_neg_c = ~p_neg_c & ~n_neg_c;
  end

  // Next state of stage 2: load results only when stage 1 holds a transaction.
  always_comb begin
    vld_p2_d   = vld_p2_q;
    n_pos_p2_d = n_pos_p2_q;
    z_pos_p2_d = z_pos_p2_q;
    p_pos_p2_d = p_pos_p2_q;
    n_neg_p2_d = n_neg_p2_q;
    z_neg_p2_d = z_neg_p2_q;
    p_neg_p2_d = p_neg_p2_q;
    f_pos_p2_d = f_pos_p2_q;
    f_neg_p2_d = f_neg_p2_q;
    if (en2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        n_pos_p2_d = n_pos_c;
        z_pos_p2_d = z_pos_c;
        p_pos_p2_d = p_pos_c;
        n_neg_p2_d = n_neg_c;
        z_neg_p2_d = z_neg_c;
        p_neg_p2_d = p_neg_c;
        f_pos_p2_d = ~z_pos_c;
        f_neg_p2_d = ~z_neg_c;
      end
    end
  end

  // Stage 2 registers; the indicators are stored rather than derived so reset reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q   <= 1'b0;
      n_pos_p2_q <= '0;
      z_pos_p2_q <= '0;
      p_pos_p2_q <= '0;
      n_neg_p2_q <= '0;
      z_neg_p2_q <= '0;
      p_neg_p2_q <= '0;
      f_pos_p2_q <= '0;
      f_neg_p2_q <= '0;
    end else begin
      vld_p2_q   <= vld_p2_d;
      n_pos_p2_q <= n_pos_p2_d;
      z_pos_p2_q <= z_pos_p2_d;
      p_pos_p2_q <= p_pos_p2_d;
      n_neg_p2_q <= n_neg_p2_d;
      z_neg_p2_q <= z_neg_p2_d;
      p_neg_p2_q <= p_neg_p2_d;
      f_pos_p2_q <= f_pos_p2_d;
      f_neg_p2_q <= f_neg_p2_d;
    end
  end

`ifdef LZA_LZC_EN
  logic [CNT_W-1:0] lzc_pos_p2_q, lzc_pos_p2_d;
  logic [CNT_W-1:0] lzc_neg_p2_q, lzc_neg_p2_d;

  // Leading-zero counts travel with the strings under the same load condition.
  always_comb begin
    lzc_pos_p2_d = lzc_pos_p2_q;
    lzc_neg_p2_d = lzc_neg_p2_q;
    if (en2 && vld_p1_q) begin
      lzc_pos_p2_d = lead_zeros(~z_pos_c);
      lzc_neg_p2_d = lead_zeros(~z_neg_c);
    end
  end

  // Count registers, cleared with the rest of stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lzc_pos_p2_q <= '0;
      lzc_neg_p2_q <= '0;
    end else begin
      lzc_pos_p2_q <= lzc_pos_p2_d;
      lzc_neg_p2_q <= lzc_neg_p2_d;
    end
  end

  assign bus.lzc_pos = lzc_pos_p2_q;
  assign bus.lzc_neg = lzc_neg_p2_q;
`else
  assign bus.lzc_pos = '0;
  assign bus.lzc_neg = '0;
`endif

  assign bus.out_valid    = vld_p2_q;
  assign bus.string_n_pos = n_pos_p2_q;
  assign bus.string_z_pos = z_pos_p2_q;
  assign bus.string_p_pos = p_pos_p2_q;
  assign bus.string_n_neg = n_neg_p2_q;
  assign bus.string_z_neg = z_neg_p2_q;
  assign bus.string_p_neg = p_neg_p2_q;
  assign bus.f_pos        = f_pos_p2_q;
  assign bus.f_neg        = f_neg_p2_q;
endmodule

// File: tb/tb_pre_encoding_pipe.sv
// Self-checking bench for pre_encoding_pipe (DATA_WIDTH=8): directed vectors, a
// backpressured stream, mid-flight reset and randomized traffic against a digit-class model.
module tb_pre_encoding_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pre_encoding_pipe_if #(.DATA_WIDTH(W)) bus ();
  pre_encoding_pipe #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_out   = 0;
  logic lat_chk = 1'b0;
  logic hold_prev = 1'b0;
  logic last_in_ready = 1'b1;
  logic [127:0] held_vec = '0;
  logic [127:0] exp_q[$];
  int           acc_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
    n_tests++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic int lz_exp(input int v);
`ifdef LZA_LZC_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic logic [127:0] pack(input logic [7:0] np, zp, pp, nn, zn, pn, fp, fn,
                                        input int lp, input int ln);
    return 128'({np, zp, pp, nn, zn, pn, fp, fn, 4'(lp), 4'(ln)});
  endfunction

  function automatic logic [127:0] observe();
    return 128'({bus.string_n_pos, bus.string_z_pos, bus.string_p_pos,
                 bus.string_n_neg, bus.string_z_neg, bus.string_p_neg,
                 bus.f_pos, bus.f_neg, bus.lzc_pos, bus.lzc_neg});
  endfunction

  // Reference: classify each digit (0 = bits differ, 1 = both one, 2 = both zero),
  // apply the string rules by class and count leading zeros arithmetically.
  function automatic logic [127:0] model(input logic [7:0] a, input logic [7:0] b, input logic sb);
    logic [7:0] bp, np, pp, zp, nn, pn, zn, fp, fn;
    int kind[W];
    bp = sb ? ~b : b;
    for (int i = 0; i < W; i++)
      kind[i] = (a[i] != bp[i]) ? 0 : (a[i] ? 1 : 2);
    for (int i = 0; i < W; i++) begin
      pp[i] = (kind[i] != 0) && (i == 0 || kind[i-1] != 2);
      np[i] = (kind[i] == 2) && (i == W - 1 || kind[i+1] != 0);
      nn[i] = (kind[i] != 0) && (i == 0 || kind[i-1] != 1);
      pn[i] = (kind[i] == 1) && (i == W - 1 || kind[i+1] != 0);
    end
    zp = ~(pp | np);
    zn = ~(pn | nn);
    fp = ~zp;
    fn = ~zn;
    return pack(np, zp, pp, nn, zn, pn, fp, fn,
                lz_exp(W - $clog2(int'(fp) + 1)), lz_exp(W - $clog2(int'(fn) + 1)));
  endfunction

  // One clock: drive at the falling edge, observe 1 time unit later, score the handshakes
  // that the next rising edge will perform.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic sb, input logic ordy, input logic [127:0] ev,
                       output logic acc);
    logic [127:0] cur;
    int qs;
    int t;
    @(negedge clk);
    bus.in_valid  = v;
    bus.data_A    = a;
    bus.data_B    = b;
    bus.sub       = sb;
    bus.out_ready = ordy;
    #1;
    qs  = exp_q.size();
    cur = observe();
    last_in_ready = bus.in_ready;
    chk("in_ready", 128'(bus.in_ready), 128'(!(qs == 2 && !ordy)));
    if (hold_prev) begin
      chk("hold_valid", 128'(bus.out_valid), 128'(1));
      chk("hold_data", cur, held_vec);
    end
    if (bus.out_valid && ordy) begin
      chk("out_has_txn", 128'(qs > 0), 128'(1));
      if (qs > 0) begin
        chk("data", cur, exp_q.pop_front());
        t = acc_q.pop_front();
        if (lat_chk) chk("latency", 128'(cyc - t), 128'(2));
        n_out++;
      end
    end
    hold_prev = bus.out_valid & ~ordy;
    held_vec  = cur;
    acc = v & bus.in_ready;
    if (acc) begin
      exp_q.push_back(ev);
      acc_q.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, '0, acc);
  endtask

  task automatic run_dir(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sb, input logic [127:0] ev);
    logic acc;
    cycle(1'b1, a, b, sb, 1'b1, ev, acc);
    chk(tag, 128'(acc), 128'(1));
    idle(3);
    chk({tag, "_done"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic directed_set();
    run_dir("dir1", 8'h00, 8'h00, 1'b0,
            pack(8'hFF, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, lz_exp(0), lz_exp(0)));
    run_dir("dir2", 8'hFF, 8'h00, 1'b0,
            pack(8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, lz_exp(8), lz_exp(8)));
    run_dir("dir3", 8'h05, 8'h05, 1'b1,
            pack(8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, lz_exp(8), lz_exp(8)));
    run_dir("dir4", 8'h80, 8'h00, 1'b0,
            pack(8'h3F, 8'hC0, 8'h01, 8'h7F, 8'h80, 8'h00, 8'h3F, 8'h7F, lz_exp(2), lz_exp(1)));
  endtask

  task automatic random_phase(input int n, input logic bp_en);
    logic acc, pend, ordy;
    logic [7:0] a, b;
    logic sb;
    pend = 1'b0;
    a = '0; b = '0; sb = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!pend && $urandom_range(0, 9) < 7) begin
        pend = 1'b1;
        a  = 8'($urandom);
        sb = 1'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? (sb ? ~a : a) : 8'($urandom);
      end
      ordy = bp_en ? ($urandom_range(0, 9) < 6) : 1'b1;
      cycle(pend, a, b, sb, ordy, model(a, b, sb), acc);
      if (acc) pend = 1'b0;
    end
    idle(6);
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc, saw_drop;
    logic [7:0] sa[5], sbv[5];
    logic       ss[5];
    int idx, out0;
    bus.in_valid = 1'b0; bus.data_A = '0; bus.data_B = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_outputs", observe(), '0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;

    lat_chk = 1'b1;
    directed_set();

    // Backpressured stream of five transactions.
    lat_chk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sa[i] = 8'($urandom); sbv[i] = 8'($urandom); ss[i] = 1'($urandom);
    end
    idx = 0; saw_drop = 1'b0; out0 = n_out;
    for (int k = 1; k <= 40 && (idx < 5 || exp_q.size() > 0); k++) begin
      if (idx < 5)
        cycle(1'b1, sa[idx], sbv[idx], ss[idx], !(k >= 3 && k <= 5),
              model(sa[idx], sbv[idx], ss[idx]), acc);
      else
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, '0, acc);
      if (!last_in_ready) saw_drop = 1'b1;
      if (acc) idx++;
    end
    chk("stream_in_ready_drop", 128'(saw_drop), 128'(1));
    chk("stream_accepted", 128'(idx), 128'(5));
    chk("stream_emitted", 128'(n_out - out0), 128'(5));

    // Reset with two transactions in flight.
    cycle(1'b1, 8'h12, 8'h34, 1'b0, 1'b1, model(8'h12, 8'h34, 1'b0), acc);
    cycle(1'b1, 8'h56, 8'h78, 1'b1, 1'b1, model(8'h56, 8'h78, 1'b1), acc);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 128'(bus.out_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_outputs", observe(), '0);
    exp_q.delete();
    acc_q.delete();
    hold_prev = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_out_valid", 128'(bus.out_valid), 128'(0));

    lat_chk = 1'b1;
    directed_set();

    lat_chk = 1'b0;
    random_phase(400, 1'b1);
    lat_chk = 1'b1;
    random_phase(150, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
